// File: rtl/pipeline_control.sv
// pipeline_control: PC enable and per-latch enable/flush sequencing for the 5-stage pipeline,
// covering load-use, branch, jump, memory waits and halt drain to a sticky halted state.
module pipeline_control #(
    parameter int HALT_DRAIN = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] id_rsel1,
    input  logic [4:0] id_rsel2,
    input  logic       id_jump,
    input  logic       id_halt,
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic       ex_branch_taken,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic       halt_out,
    output logic [1:0] state
);
    localparam int CW = $clog2(HALT_DRAIN + 1);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dstall, lu;
    assign dstall = (mem_dREN | mem_dWEN) & ~dhit;
    assign lu = ex_dREN & (ex_wsel != 5'd0) & (ex_wsel == id_rsel1 | ex_wsel == id_rsel2);
    assign state = RST ? 2'd0 : state_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pc_en = 1'b1;
        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
        {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0000;
        halt_out = 1'b0;
        case (state_q)
            RUN: begin
                if (dstall) begin
                    pc_en = 1'b0;
                    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b0000;
                end else if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_en = 1'b0;
                    ifid_en = 1'b0;
                    idex_flush = 1'b1;
                end else if (~ihit) begin
                    pc_en = 1'b0;
                    ifid_flush = 1'b1;
                end else if (id_halt) begin
                    pc_en = 1'b0;
                    ifid_flush = 1'b1;
                    state_d = DRAIN;
                    cnt_d = CW'(HALT_DRAIN);
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                // Front end stays bubbled; only older instructions keep moving.
                pc_en = 1'b0;
                ifid_flush = 1'b1;
                if (dstall) begin
                    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b0000;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = HALTED;
                end
            end
            HALTED: begin
                pc_en = 1'b0;
                {ifid_en, idex_en, exmem_en, memwb_en} = 4'b0000;
                halt_out = 1'b1;
            end
            default: state_d = RUN;
        endcase
        if (RST) begin
            pc_en = 1'b0;
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b0000;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
            halt_out = 1'b0;
        end
    end
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed and random stimulus against a rule-level model of the
// pipeline controller (priority rules plus a countdown of remaining drain cycles).
module tb_pipeline_control;
    localparam int HD = 3;
    logic CLK = 1'b0;
    logic RST, ihit, dhit, id_jump, id_halt, ex_dREN, ex_branch_taken, mem_dREN, mem_dWEN;
    logic [4:0] id_rsel1, id_rsel2, ex_wsel;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out;
    logic [1:0] state;
    int total = 0;
    int bad = 0;
    int m_state = 0;
    int m_left = 0;

    always #5 CLK = ~CLK;

    pipeline_control #(.HALT_DRAIN(HD)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_jump(id_jump), .id_halt(id_halt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_branch_taken(ex_branch_taken),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .halt_out(halt_out), .state(state)
    );

    function automatic bit ds_f();
        return (mem_dREN | mem_dWEN) & ~dhit;
    endfunction

    function automatic bit lu_f();
        return ex_dREN && ex_wsel != 0 && (ex_wsel == id_rsel1 || ex_wsel == id_rsel2);
    endfunction

    // {pc_en, en[ifid,idex,exmem,memwb], flush[ifid,idex,exmem,memwb], halt_out, state}
    function automatic logic [11:0] expv();
        if (RST) return {1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
        if (m_state == 2) return {1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2};
        if (m_state == 1) return {1'b0, ds_f() ? 4'b0000 : 4'b1111, 4'b1000, 1'b0, 2'd1};
        if (ds_f()) return {1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        if (ex_branch_taken) return {1'b1, 4'b1111, 4'b1100, 1'b0, 2'd0};
        if (lu_f()) return {1'b0, 4'b0111, 4'b0100, 1'b0, 2'd0};
        if (!ihit || id_halt) return {1'b0, 4'b1111, 4'b1000, 1'b0, 2'd0};
        if (id_jump) return {1'b1, 4'b1111, 4'b1000, 1'b0, 2'd0};
        return {1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0};
    endfunction

    task automatic settle(input string tag);
        logic [11:0] e, o, m;
        @(negedge CLK);
        e = expv();
        m = 12'hfff;
        if (!RST && m_state == 1 && !ds_f()) m[10] = 1'b0;
        o = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out, state};
        total++;
        assert ((o & m) === (e & m)) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, o & m, e & m);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        total++;
        assert (o === e) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        if (RST) begin
            m_state = 0;
            m_left = 0;
        end else if (m_state == 0) begin
            if (!ds_f() && !ex_branch_taken && !lu_f() && ihit && id_halt) begin
                m_state = 1;
                m_left = HD;
            end
        end else if (m_state == 1 && !ds_f()) begin
            m_left--;
            if (m_left == 0) m_state = 2;
        end
        #1;
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 0; id_jump = 0; id_halt = 0; ex_dREN = 0;
        ex_branch_taken = 0; mem_dREN = 0; mem_dWEN = 0;
        id_rsel1 = 0; id_rsel2 = 0; ex_wsel = 0;
    endtask

    task automatic rnd(input bit allow_rst);
        RST = allow_rst && ($urandom_range(0, 40) == 0);
        ihit = $urandom_range(0, 3) != 0;
        dhit = 1'($urandom);
        mem_dREN = $urandom_range(0, 3) == 0;
        mem_dWEN = $urandom_range(0, 5) == 0;
        id_rsel1 = 5'($urandom_range(0, 3));
        id_rsel2 = 5'($urandom_range(0, 3));
        ex_wsel = 5'($urandom_range(0, 3));
        ex_dREN = 1'($urandom);
        ex_branch_taken = $urandom_range(0, 7) == 0;
        id_jump = $urandom_range(0, 7) == 0;
        id_halt = $urandom_range(0, 9) == 0;
    endtask

    initial begin
        idle();
        RST = 1; ihit = 0;
        for (int i = 0; i < 2; i++) begin
            settle("reset");
            chk("reset_pc_flush_halt", {pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out, state}, 12'b0_1111_0_00);
            adv();
        end
        idle();
        settle("run");
        chk("run_all_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 12'b11111_00);
        adv();
        ex_dREN = 1; ex_wsel = 5; id_rsel2 = 5;
        settle("lu");
        chk("lu_stall", {pc_en, ifid_en, idex_flush}, 12'b001);
        adv();
        ex_dREN = 0;
        settle("lu_after");
        chk("lu_one_cycle", {pc_en, ifid_en, idex_flush}, 12'b110);
        adv();
        ex_dREN = 1; ex_wsel = 0; id_rsel2 = 0;
        settle("lu_r0");
        chk("lu_r0_no_stall", {pc_en, ifid_en, idex_flush}, 12'b110);
        adv();
        ex_wsel = 7; id_rsel1 = 7; ihit = 0; id_jump = 1; ex_branch_taken = 1;
        settle("branch");
        chk("branch_over_all", {pc_en, ifid_flush, idex_flush, exmem_en}, 12'b1111);
        adv();
        idle();
        mem_dREN = 1;
        for (int i = 0; i < 3; i++) begin
            settle("dstall");
            chk("dstall_freeze", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush}, 12'b0);
            adv();
        end
        dhit = 1;
        settle("dstall_done");
        chk("dstall_release", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 12'b11111);
        adv();
        idle();
        id_halt = 1;
        settle("halt_c0");
        chk("halt_c0_state", state, 12'd0);
        adv();
        id_halt = 0;
        for (int c = 1; c <= 3; c++) begin
            settle("halt_drain");
            chk("halt_drain_state", {halt_out, state}, 12'b0_01);
            adv();
        end
        settle("halt_c4");
        chk("halt_c4", {halt_out, state}, 12'b1_10);
        adv();
        for (int i = 0; i < 10; i++) begin
            rnd(0);
            settle("halted_rand");
            chk("halted_sticky", halt_out, 12'd1);
            adv();
        end
        idle();
        RST = 1;
        settle("halt_rst");
        chk("halt_rst_clear", {halt_out, state}, 12'b0);
        adv();
        idle();
        id_halt = 1;
        settle("halt2_c0");
        adv();
        idle();
        for (int c = 1; c <= 5; c++) begin
            mem_dWEN = (c == 2 || c == 3);
            settle("halt2_drain");
            chk("halt2_not_yet", {halt_out, state}, 12'b0_01);
            adv();
        end
        idle();
        settle("halt2_c6");
        chk("halt2_c6", {halt_out, state}, 12'b1_10);
        adv();
        RST = 1;
        settle("rst2");
        adv();
        idle();
        id_halt = 1; ex_branch_taken = 1;
        settle("halt_br");
        adv();
        idle();
        settle("halt_br_next");
        chk("halt_br_run", {halt_out, state}, 12'b0);
        adv();
        for (int i = 0; i < 500; i++) begin
            rnd(1);
            settle("rand");
            adv();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_control.md
# pipeline_control

Sequencing controller for the 5-stage MIPS pipeline. Sits beside the decode unit and drives the PC enable and the per-stage enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves load-use hazards, taken branches, jumps, instruction and data memory waits, and halt drain. After a halt has drained the pipeline, the block freezes the pipeline and asserts a sticky halt.

## Interface

- HALT_DRAIN, 3: cycles needed after halt leaves decode for all older instructions to retire. Minimum 1.

- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access in MEM completes this cycle
- id_rsel1, id_rsel2  in  5 (regbits_t)  source registers of the instruction in ID
- id_jump  in  1  ID holds J/JAL/JR; PC redirects from decode
- id_halt  in  1  ID holds halt
- ex_dREN  in  1  EX holds a load
- ex_wsel  in  5 (regbits_t)  destination register of the EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch
- mem_dREN, mem_dWEN  in  1  MEM has a data access pending
- pc_en  out  1  PC register loads next PC
- ifid_en, idex_en, exmem_en, memwb_en  out  1  latch advances
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  latch loads a bubble on the next edge (overrides enable)
- halt_out  out  1  pipeline halted
- state  out  2  debug: RUN=0, DRAIN=1, HALTED=2

## Operation

- Registers: state, drain counter cnt of width $clog2(HALT_DRAIN+1). All outputs are combinational from state and inputs.
- Terms:
  - dstall = (mem_dREN | mem_dWEN) & ~dhit
  - lu = ex_dREN & (ex_wsel != 0) & (ex_wsel == id_rsel1 | ex_wsel == id_rsel2)
- **RUN** rules, first match wins. Any output not listed is en=1, flush=0.
  1. dstall: all en=0, all flush=0, pc_en=0.
  2. ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1. This overrides lu, ihit=0, id_jump and id_halt. The in-flight fetch is discarded.
  3. lu: pc_en=0, ifid_en=0, idex_flush=1.
  4. ~ihit: pc_en=0, ifid_flush=1.
  5. id_halt: pc_en=0, ifid_flush=1. Next state is DRAIN with cnt=HALT_DRAIN.
  6. id_jump: pc_en=1, ifid_flush=1.
  7. Otherwise all advance.
- **DRAIN**:
  - pc_en=0 and ifid_flush=1 always.
  - If dstall: every latch en=0 and cnt holds.
  - Otherwise idex, exmem and memwb advance, and cnt decrements.
  - ex_branch_taken, lu, ihit and id_jump are ignored.
  - When cnt==1 and ~dstall, next state is HALTED.
- **HALTED**:
  - All en=0, all flush=0, halt_out=1.
  - Sticky until RST. All inputs are ignored.
- halt_out=0 in RUN and DRAIN.
- An id_halt that is younger than a taken branch is flushed and never enters DRAIN.

## Timing

- Reset: while RST is high, outputs are forced to en=0, every flush=1, halt_out=0 and state=RUN. On the edge with RST high, state←RUN and cnt←0. RST mid-DRAIN or in HALTED returns to RUN on that edge.
- Hazard responses (load-use, branch, jump, wait) are combinational in the same cycle; the latches act on the next edge.
- A load-use stall lasts exactly 1 cycle, provided no dstall occurs. On the next cycle the load is in MEM, so lu=0.
- Halt latency: id_halt sampled in RUN in cycle 0 gives halt_out=1 from cycle HALT_DRAIN+1 onward. Each dstall cycle in DRAIN adds 1 cycle.
- A dstall in RUN concurrent with id_halt leaves state in RUN; halt is re-evaluated the next cycle.

## Test plan

- RST high 2 cycles → pc_en=0, all flush=1, halt_out=0, state=0. Release with ihit=1, dhit=0, no mem access → all en=1, no flush.
- Load-use: ex_dREN=1, ex_wsel=5, id_rsel2=5 → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle. Same stimulus with ex_wsel=0 → no stall.
- Simultaneous ex_branch_taken=1, lu=1, ihit=0, id_jump=1 → pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1.
- mem_dREN=1 with dhit=0 for 3 cycles → all en=0, no flush for 3 cycles. dhit=1 on cycle 4 → normal advance.
- HALT_DRAIN=3, id_halt=1 in cycle 0 → state=DRAIN in cycles 1-3, halt_out=1 from cycle 4. Repeat with dhit=0 and mem_dWEN=1 in cycles 2-3 → halt_out from cycle 6. halt_out stays high for 10 further cycles with random inputs, then clears on RST.
- id_halt=1 with ex_branch_taken=1 → state stays RUN and halt_out stays 0.
